reorder_buffer: RTL and testbench

In-order retirement buffer for the OoO core, between dispatch (allocate) and register-file writeback (retire).
- Dispatch allocates one entry per instruction in program order and receives a tag.
- Execution units report results by tag, in any order.
- Completed results leave in program order, one per cycle, toward the architectural register file.
- Instantiated inside CPU; clocked by the same clk/rstn as the rest of the core.

---
 rtl/reorder_buffer_if.sv | 33 +++
 rtl/reorder_buffer.sv | 124 ++++++++++++
 tb/tb_reorder_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / retirement bundle of the reorder buffer.
// master: dispatch + execution side (drives flush, alloc_*, cmp_*; observes ready/tag/ret_*/count).
// slave : the reorder buffer itself.
interface reorder_buffer_if #(
  parameter int TAG_W = 3,
  parameter int XLEN  = 32
);
  logic             flush;
  logic             alloc_valid;
  logic             alloc_has_rd;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             cmp_valid;
  logic [TAG_W-1:0] cmp_tag;
  logic [XLEN-1:0]  cmp_data;
  logic             ret_valid;
  logic             ret_we;
  logic [4:0]       ret_rd;
  logic [XLEN-1:0]  ret_data;
  logic [TAG_W-1:0] ret_tag;
  logic [TAG_W:0]   count;

  modport master (
    output flush, alloc_valid, alloc_has_rd, alloc_rd, cmp_valid, cmp_tag, cmp_data,
    input  alloc_ready, alloc_tag, ret_valid, ret_we, ret_rd, ret_data, ret_tag, count
  );

  modport slave (
    input  flush, alloc_valid, alloc_has_rd, alloc_rd, cmp_valid, cmp_tag, cmp_data,
    output alloc_ready, alloc_tag, ret_valid, ret_we, ret_rd, ret_data, ret_tag, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete by tag in any order, retire from head.
// Latency: a completion at edge N retires at edge N+1 at the earliest; ret_* are registered.
// Backpressure: alloc_ready drops when count == DEPTH; retire side has no backpressure.
// Ports: clk, rstn (async active-low), rob (slave modport of reorder_buffer_if).
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  reorder_buffer_if.slave  rob
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  // Per-entry state
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] has_rd_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];

  logic [TAG_W-1:0] head_q, tail_q;
  logic [TAG_W:0]   count_q, count_d;

  logic             ret_valid_q, ret_we_q;
  logic [4:0]       ret_rd_q;
  logic [XLEN-1:0]  ret_data_q;
  logic [TAG_W-1:0] ret_tag_q;

  logic alloc_ready;
  logic alloc_fire;
  logic retire_fire;
  logic cmp_hit;

  assign alloc_ready = (count_q != FULL_CNT);
  assign alloc_fire  = rob.alloc_valid && alloc_ready;
  assign retire_fire = (count_q != '0) && done_q[head_q];
  assign cmp_hit     = rob.cmp_valid && valid_q[rob.cmp_tag];

  always_comb begin
    count_d = count_q;
    if (alloc_fire && !retire_fire) begin
      count_d = count_q + 1'b1;
    end else if (!alloc_fire && retire_fire) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state. Update order within the edge matters: completion, then
  // allocation, then the retire clear, so a completion racing the retire of
  // the same head entry cannot leave a stale done bit behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q     <= '0;
      done_q      <= '0;
      has_rd_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ret_valid_q <= 1'b0;
      ret_we_q    <= 1'b0;
      ret_rd_q    <= '0;
      ret_data_q  <= '0;
      ret_tag_q   <= '0;
    end else if (rob.flush) begin
      valid_q     <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ret_valid_q <= 1'b0;
      ret_we_q    <= 1'b0;
    end else begin
      if (cmp_hit) begin
        done_q[rob.cmp_tag] <= 1'b1;
      end
      if (alloc_fire) begin
        valid_q[tail_q]  <= 1'b1;
        done_q[tail_q]   <= 1'b0;
        has_rd_q[tail_q] <= rob.alloc_has_rd;
        tail_q           <= tail_q + 1'b1;
      end
      if (retire_fire) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
        ret_valid_q     <= 1'b1;
        ret_we_q        <= has_rd_q[head_q];
        ret_rd_q        <= rd_q[head_q];
        ret_data_q      <= data_q[head_q];
        ret_tag_q       <= head_q;
      end else begin
        // Payload fields hold their last retired values.
        ret_valid_q <= 1'b0;
        ret_we_q    <= 1'b0;
      end
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: it is only read behind valid/done.
  always_ff @(posedge clk) begin
    if (!rob.flush) begin
      if (cmp_hit) begin
        data_q[rob.cmp_tag] <= rob.cmp_data;
      end
      if (alloc_fire) begin
        rd_q[tail_q] <= rob.alloc_rd;
      end
    end
  end

  assign rob.alloc_ready = alloc_ready;
  assign rob.alloc_tag   = tail_q;
  assign rob.ret_valid   = ret_valid_q;
  assign rob.ret_we      = ret_we_q;
  assign rob.ret_rd      = ret_rd_q;
  assign rob.ret_data    = ret_data_q;
  assign rob.ret_tag     = ret_tag_q;
  assign rob.count       = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table for in-order retirement
// and no-rd retire, plus hand sequences for reset, full, flush and wrap.
module tb_reorder_buffer;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  reorder_buffer_if #(.TAG_W(3), .XLEN(32)) bus ();

  reorder_buffer #(.DEPTH(8), .TAG_W(3), .XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rob  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        av;
    logic        hrd;
    logic [4:0]  rd;
    logic        cv;
    logic [2:0]  ct;
    logic [31:0] cd;
    logic        e_rv;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [2:0]  e_tag;
    logic [3:0]  e_cnt;
    logic        e_ardy;
    logic [2:0]  e_atag;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mkv(logic fl, logic av, logic hrd, logic [4:0] rd,
                               logic cv, logic [2:0] ct, logic [31:0] cd,
                               logic e_rv, logic e_we, logic [4:0] e_rd,
                               logic [31:0] e_data, logic [2:0] e_tag,
                               logic [3:0] e_cnt, logic e_ardy, logic [2:0] e_atag);
    vec_t v;
    v.flush = fl; v.av = av; v.hrd = hrd; v.rd = rd;
    v.cv = cv; v.ct = ct; v.cd = cd;
    v.e_rv = e_rv; v.e_we = e_we; v.e_rd = e_rd; v.e_data = e_data;
    v.e_tag = e_tag; v.e_cnt = e_cnt; v.e_ardy = e_ardy; v.e_atag = e_atag;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic av, input logic hrd, input logic [4:0] rd,
                       input logic cv, input logic [2:0] ct, input logic [31:0] cd);
    bus.flush        = fl;
    bus.alloc_valid  = av;
    bus.alloc_has_rd = hrd;
    bus.alloc_rd     = rd;
    bus.cmp_valid    = cv;
    bus.cmp_tag      = ct;
    bus.cmp_data     = cd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rdf(input int seq);
    return 5'((seq + 3) % 32);
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    idle();

    // Initial reset state
    #12;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ret_valid", 32'(bus.ret_valid), 32'd0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_alloc_tag", 32'(bus.alloc_tag), 32'd0);
    rstn = 1'b1;

    // Out-of-order completion, in-order retire; then a no-rd instruction
    // and a completion to an unallocated tag.
    //            fl av hrd rd     cv ct    cd      | rv we rd     data    tag  cnt ardy atag
    tbl[0]  = mkv(0, 1, 1, 5'd5,  0, 3'd0, 32'h0,   0, 0, 5'd0,  32'h0,  3'd0, 4'd1, 1, 3'd1);
    tbl[1]  = mkv(0, 1, 1, 5'd6,  0, 3'd0, 32'h0,   0, 0, 5'd0,  32'h0,  3'd0, 4'd2, 1, 3'd2);
    tbl[2]  = mkv(0, 1, 1, 5'd7,  0, 3'd0, 32'h0,   0, 0, 5'd0,  32'h0,  3'd0, 4'd3, 1, 3'd3);
    tbl[3]  = mkv(0, 0, 0, 5'd0,  1, 3'd2, 32'h33,  0, 0, 5'd0,  32'h0,  3'd0, 4'd3, 1, 3'd3);
    tbl[4]  = mkv(0, 0, 0, 5'd0,  1, 3'd0, 32'h11,  0, 0, 5'd0,  32'h0,  3'd0, 4'd3, 1, 3'd3);
    tbl[5]  = mkv(0, 0, 0, 5'd0,  1, 3'd1, 32'h22,  1, 1, 5'd5,  32'h11, 3'd0, 4'd2, 1, 3'd3);
    tbl[6]  = mkv(0, 0, 0, 5'd0,  0, 3'd0, 32'h0,   1, 1, 5'd6,  32'h22, 3'd1, 4'd1, 1, 3'd3);
    tbl[7]  = mkv(0, 0, 0, 5'd0,  0, 3'd0, 32'h0,   1, 1, 5'd7,  32'h33, 3'd2, 4'd0, 1, 3'd3);
    tbl[8]  = mkv(0, 0, 0, 5'd0,  0, 3'd0, 32'h0,   0, 0, 5'd7,  32'h33, 3'd2, 4'd0, 1, 3'd3);
    tbl[9]  = mkv(0, 1, 0, 5'd9,  0, 3'd0, 32'h0,   0, 0, 5'd7,  32'h33, 3'd2, 4'd1, 1, 3'd4);
    tbl[10] = mkv(0, 0, 0, 5'd0,  1, 3'd3, 32'hAB,  0, 0, 5'd7,  32'h33, 3'd2, 4'd1, 1, 3'd4);
    tbl[11] = mkv(0, 0, 0, 5'd0,  0, 3'd0, 32'h0,   1, 0, 5'd9,  32'hAB, 3'd3, 4'd0, 1, 3'd4);
    tbl[12] = mkv(0, 0, 0, 5'd0,  1, 3'd5, 32'h55,  0, 0, 5'd9,  32'hAB, 3'd3, 4'd0, 1, 3'd4);
    tbl[13] = mkv(0, 0, 0, 5'd0,  0, 3'd0, 32'h0,   0, 0, 5'd9,  32'hAB, 3'd3, 4'd0, 1, 3'd4);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].flush, tbl[i].av, tbl[i].hrd, tbl[i].rd, tbl[i].cv, tbl[i].ct, tbl[i].cd);
      step();
      chk($sformatf("v%0d_ret_valid", i), 32'(bus.ret_valid), 32'(tbl[i].e_rv));
      chk($sformatf("v%0d_ret_we", i), 32'(bus.ret_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_ret_rd", i), 32'(bus.ret_rd), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d_ret_data", i), bus.ret_data, tbl[i].e_data);
      chk($sformatf("v%0d_ret_tag", i), 32'(bus.ret_tag), 32'(tbl[i].e_tag));
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_alloc_ready", i), 32'(bus.alloc_ready), 32'(tbl[i].e_ardy));
      chk($sformatf("v%0d_alloc_tag", i), 32'(bus.alloc_tag), 32'(tbl[i].e_atag));
    end
    idle();

    // Asynchronous reset mid-run with entries present
    drive(1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 3'd0, 32'd0);
    step();
    step();
    idle();
    chk("pre_rst_count", 32'(bus.count), 32'd2);
    #2 rstn = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_ret_valid", 32'(bus.ret_valid), 32'd0);
    chk("arst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("arst_alloc_tag", 32'(bus.alloc_tag), 32'd0);
    rstn = 1'b1;
    step();
    chk("post_rst_count", 32'(bus.count), 32'd0);
    chk("post_rst_ret_data", bus.ret_data, 32'd0);

    // Fill to DEPTH, refuse a 9th, retire one, reuse tag 0
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1, 5'(i + 10), 1'b0, 3'd0, 32'd0);
      chk($sformatf("fill%0d_alloc_tag", i), 32'(bus.alloc_tag), 32'(i));
      chk($sformatf("fill%0d_alloc_ready", i), 32'(bus.alloc_ready), 32'd1);
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 5'd30, 1'b0, 3'd0, 32'd0);
    chk("full_count", 32'(bus.count), 32'd8);
    chk("full_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    step();
    chk("full_9th_count", 32'(bus.count), 32'd8);
    chk("full_9th_alloc_tag", 32'(bus.alloc_tag), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'h77);
    step();
    chk("full_cmp_count", 32'(bus.count), 32'd8);
    chk("full_cmp_ret_valid", 32'(bus.ret_valid), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 5'd20, 1'b0, 3'd0, 32'd0);
    chk("full_retire_cycle_ready", 32'(bus.alloc_ready), 32'd0);
    step();
    chk("full_ret_valid", 32'(bus.ret_valid), 32'd1);
    chk("full_ret_tag", 32'(bus.ret_tag), 32'd0);
    chk("full_ret_rd", 32'(bus.ret_rd), 32'd10);
    chk("full_ret_data", bus.ret_data, 32'h77);
    chk("full_after_count", 32'(bus.count), 32'd7);
    chk("full_after_ready", 32'(bus.alloc_ready), 32'd1);
    chk("full_after_tag", 32'(bus.alloc_tag), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 5'd21, 1'b0, 3'd0, 32'd0);
    step();
    chk("refill_count", 32'(bus.count), 32'd8);
    chk("refill_alloc_tag", 32'(bus.alloc_tag), 32'd1);
    chk("refill_ret_valid", 32'(bus.ret_valid), 32'd0);

    // Flush with alloc and complete in the same edge
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
    step();
    chk("flush0_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 5'(i + 1), 1'b0, 3'd0, 32'd0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'hA0);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 3'd1, 32'hA1);
    step();
    chk("preflush_ret_valid", 32'(bus.ret_valid), 32'd1);
    chk("preflush_count", 32'(bus.count), 32'd4);
    drive(1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 3'd2, 32'hA2);
    step();
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_ret_valid", 32'(bus.ret_valid), 32'd0);
    chk("flush_ret_we", 32'(bus.ret_we), 32'd0);
    chk("flush_alloc_tag", 32'(bus.alloc_tag), 32'd0);
    chk("flush_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 3'd2, 32'hA2);
    step();
    idle();
    step();
    chk("stale_cmp_ret_valid", 32'(bus.ret_valid), 32'd0);
    chk("stale_cmp_count", 32'(bus.count), 32'd0);

    // Steady occupancy with tag wrap
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, 1'b1, 1'b1, rdf(s), 1'b0, 3'd0, 32'd0);
      step();
    end
    for (int j = 0; j < 20; j++) begin
      drive(1'b0, 1'b1, 1'b1, rdf(j + 2), 1'b1, 3'(j % 8), 32'h100 + 32'(j));
      step();
      chk($sformatf("wrap%0d_count", j), 32'(bus.count), 32'd3);
      if (j == 0) begin
        chk("wrap0_ret_valid", 32'(bus.ret_valid), 32'd0);
      end else begin
        chk($sformatf("wrap%0d_ret_valid", j), 32'(bus.ret_valid), 32'd1);
        chk($sformatf("wrap%0d_ret_tag", j), 32'(bus.ret_tag), 32'((j - 1) % 8));
        chk($sformatf("wrap%0d_ret_rd", j), 32'(bus.ret_rd), 32'(rdf(j - 1)));
        chk($sformatf("wrap%0d_ret_data", j), bus.ret_data, 32'h100 + 32'(j - 1));
      end
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
